ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
- Input-side counterpart to the VGA text adapter: receives PS/2 keyboard frames, decodes scan-code set 2 make/break sequences, and translates key presses to ASCII.
- Buffers the ASCII codes in a FIFO that the CPU drains through a pop-style read port.
- Sits beside vga_driver on the CPU IO bus; together they form the text console (keyboard in, text buffer out).

Parameters:
- FIFO_DEPTH, 16, ASCII entries buffered; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000, CLOCK_50 cycles without a PS/2 falling edge before a partial frame is discarded (1 ms).

Ports:
- CLOCK_50 in 1: the only clock; all logic on its rising edge.
- reset in 1: asynchronous, active-low; clears all state.
- PS2_CLK in 1: raw keyboard clock, asynchronous to CLOCK_50.
- PS2_DAT in 1: raw keyboard data, asynchronous to CLOCK_50.
- rd_en in 1: pop the FIFO head this cycle.
- rd_data out 8: FIFO head ASCII (first-word fall-through); 0x00 when empty.
- rd_empty out 1: FIFO empty.
- overflow out 1: sticky flag, a code was dropped because the FIFO was full.
- ovf_clr in 1: clears overflow; set wins if a drop occurs in the same cycle.
- frame_err out 1: one-cycle pulse on a parity or stop-bit error.

Behaviour:
- Reset values: rd_data=0x00, rd_empty=1, overflow=0, frame_err=0. All FSMs idle, shift state cleared, FIFO pointers 0.
- Input sync: PS2_CLK and PS2_DAT each pass through two flip-flops. A third register on the clock detects falling edges as prev=1, cur=0. Data is sampled on the edge-detect cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge with data=0 go to DATA with bit count 0. Data=1 is a bad start bit; stay in IDLE silently.
  - DATA: shift in 8 bits LSB-first; after bit 7 go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: if stop=1 and the 9 bits have odd parity, byte_valid pulses one cycle later. Otherwise frame_err pulses for one cycle and the byte is dropped. Either way return to IDLE.
- Timeout: in any state except IDLE, a counter increments every cycle and resets to 0 on each edge. When it reaches TIMEOUT_CYCLES the FSM goes to IDLE and discards bits. No frame_err is raised.
- Decoder FSM states: NORMAL, BRK, EXT, EXT_BRK. It acts on each byte_valid.
  - NORMAL: F0 goes to BRK; E0 goes to EXT; any other byte is a make code, handled as below, and the FSM stays in NORMAL.
  - BRK: the byte is a break code. 0x12 or 0x59 clears shift; anything else is ignored. Go to NORMAL.
  - EXT: F0 goes to EXT_BRK; any other byte is ignored (extended keys produce no ASCII) and the FSM goes to NORMAL.
  - EXT_BRK: ignore the byte; go to NORMAL.
- Make-code handling:
  - 0x12 or 0x59 sets shift and pushes nothing.
  - Otherwise the code goes through the LUT; if the LUT reports mapped, the ASCII value is pushed.
- LUT mapping:
  - Letters give lowercase, or uppercase when shift is set.
  - Digits 0-9 give 0x30-0x39 regardless of shift.
  - 0x29 gives 0x20, 0x5A gives 0x0A, 0x66 gives 0x08.
  - All other codes are unmapped.
- Latency: push occurs on the cycle after byte_valid. rd_empty falls the cycle after that. Total is at most 7 CLOCK_50 cycles from the raw falling edge of the stop bit.
- FIFO: $clog2(FIFO_DEPTH)+1-bit pointers; pointers wrap modulo 2·FIFO_DEPTH.
  - Empty when pointers are equal. Full when the MSBs differ and the lower bits are equal.
  - Pop when empty is ignored.
  - Push when full without a simultaneous pop drops the code and sets overflow.
  - Push and pop in the same cycle are both performed: count is unchanged, no overflow even when full. When the FIFO is empty only the push takes effect.
- Reset mid-frame or mid-sequence: everything returns to reset values immediately; the FIFO contents are lost.

Decomposition:
- Package ps2_pkg holds:
  - frame_state_t {IDLE, DATA, PARITY, STOP};
  - dec_state_t {NORMAL, BRK, EXT, EXT_BRK};
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59.
- One sub-module, ps2_scancode_lut: combinational; inputs scancode[7:0] and shift; outputs ascii[7:0] and mapped.
- The FIFO stays inline.

Test Plan:
- Send frame 0x1C (parity bit 0) -> rd_empty falls; rd_data=0x61; pulse rd_en -> rd_empty=1, rd_data=0x00.
- Send 12, 1C, F0 1C, F0 12, 1C -> FIFO holds 0x41 then 0x61; the break bytes push nothing.
- Send 0x1C with parity bit forced to 1 -> frame_err pulses once; FIFO stays empty. Repeat with stop bit=0 -> same result.
- Send E0 75, E0 F0 75, then 0x16 -> only 0x31 is pushed.
- Send 17 presses of 0x1C with no reads -> 16 entries of 0x61 and overflow=1. Assert ovf_clr -> overflow=0. When full, assert rd_en in the same cycle as a push -> count stays 16 and overflow stays 0.
- Send start bit plus 3 data bits, idle 50000 cycles, then a full 0x29 frame -> rd_data=0x20 and frame_err never pulses. Assert reset mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

    // Bit-level frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Scan-code set 2 prefix tracking states
    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Either shift key; both share one modifier flag
    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scancode_lut.sv
// Scan-code set 2 make code to ASCII translation (letters, digits,
// space, enter, backspace). Purely combinational.
module ps2_scancode_lut (
    input  logic [7:0] scancode,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       mapped
);

    logic [7:0] lower;

    // Letters resolve to a lowercase code first so shift is applied in one place
    always_comb begin
        lower  = 8'h00;
        ascii  = 8'h00;
        mapped = 1'b0;
        case (scancode)
            8'h1C: lower = 8'h61; // a
            8'h32: lower = 8'h62; // b
            8'h21: lower = 8'h63; // c
            8'h23: lower = 8'h64; // d
            8'h24: lower = 8'h65; // e
            8'h2B: lower = 8'h66; // f
            8'h34: lower = 8'h67; // g
            8'h33: lower = 8'h68; // h
            8'h43: lower = 8'h69; // i
            8'h3B: lower = 8'h6A; // j
            8'h42: lower = 8'h6B; // k
            8'h4B: lower = 8'h6C; // l
            8'h3A: lower = 8'h6D; // m
            8'h31: lower = 8'h6E; // n
            8'h44: lower = 8'h6F; // o
            8'h4D: lower = 8'h70; // p
            8'h15: lower = 8'h71; // q
            8'h2D: lower = 8'h72; // r
            8'h1B: lower = 8'h73; // s
            8'h2C: lower = 8'h74; // t
            8'h3C: lower = 8'h75; // u
            8'h2A: lower = 8'h76; // v
            8'h1D: lower = 8'h77; // w
            8'h22: lower = 8'h78; // x
            8'h35: lower = 8'h79; // y
            8'h1A: lower = 8'h7A; // z
            8'h45: begin ascii = 8'h30; mapped = 1'b1; end
            8'h16: begin ascii = 8'h31; mapped = 1'b1; end
            8'h1E: begin ascii = 8'h32; mapped = 1'b1; end
            8'h26: begin ascii = 8'h33; mapped = 1'b1; end
            8'h25: begin ascii = 8'h34; mapped = 1'b1; end
            8'h2E: begin ascii = 8'h35; mapped = 1'b1; end
            8'h36: begin ascii = 8'h36; mapped = 1'b1; end
            8'h3D: begin ascii = 8'h37; mapped = 1'b1; end
            8'h3E: begin ascii = 8'h38; mapped = 1'b1; end
            8'h46: begin ascii = 8'h39; mapped = 1'b1; end
            8'h29: begin ascii = 8'h20; mapped = 1'b1; end // space
            8'h5A: begin ascii = 8'h0A; mapped = 1'b1; end // enter -> LF
            8'h66: begin ascii = 8'h08; mapped = 1'b1; end // backspace
            default: begin
                ascii  = 8'h00;
                mapped = 1'b0;
            end
        endcase
        if (lower != 8'h00) begin
            mapped = 1'b1;
            ascii  = shift ? (lower - 8'h20) : lower;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, assembles
// 11-bit frames, decodes set-2 make/break/extended sequences, and queues
// the resulting ASCII codes in a first-word-fall-through FIFO.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_empty,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Input synchronisers; [2] of the clock chain is the previous sample
    // ------------------------------------------------------------------
    logic [2:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       ps2_fall;
    logic       ps2_bit;

    // Two-flop synchronisers plus one history flop for edge detection;
    // preset high so reset release never looks like a falling edge
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign ps2_bit  = dat_sync_q[1];

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    frame_state_t    fstate_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shreg_q;
    logic            par_q;
    logic [TW-1:0]   tmo_q;
    logic            byte_valid_q;
    logic [7:0]      byte_q;
    logic            frame_err_q;

    // Start/data/parity/stop sequencing with an inactivity timeout that
    // silently abandons a partial frame
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            fstate_q     <= IDLE;
            bitcnt_q     <= 3'd0;
            shreg_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (ps2_fall) begin
                tmo_q <= '0;
                case (fstate_q)
                    IDLE: begin
                        // A high start bit is line noise; ignore it
                        if (!ps2_bit) begin
                            fstate_q <= DATA;
                            bitcnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg_q  <= {ps2_bit, shreg_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            fstate_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q    <= ps2_bit;
                        fstate_q <= STOP;
                    end
                    STOP: begin
                        fstate_q <= IDLE;
                        if (ps2_bit && (^{par_q, shreg_q})) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= shreg_q;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                    end
                    default: fstate_q <= IDLE;
                endcase
            end else if (fstate_q != IDLE) begin
                if (tmo_q == TMO_LIMIT) begin
                    fstate_q <= IDLE;
                    tmo_q    <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------
    dec_state_t dstate_q;
    logic       shift_q;
    logic       push_q;
    logic [7:0] push_data_q;
    logic [7:0] lut_ascii;
    logic       lut_mapped;

    ps2_scancode_lut u_lut (
        .scancode (byte_q),
        .shift    (shift_q),
        .ascii    (lut_ascii),
        .mapped   (lut_mapped)
    );

    // Prefix tracking and shift modifier; a mapped make code produces a
    // one-cycle push request on the following cycle
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            dstate_q    <= NORMAL;
            shift_q     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
        end else begin
            push_q <= 1'b0;
            if (byte_valid_q) begin
                case (dstate_q)
                    NORMAL: begin
                        if (byte_q == SC_BREAK) begin
                            dstate_q <= BRK;
                        end else if (byte_q == SC_EXT) begin
                            dstate_q <= EXT;
                        end else if (is_shift_code(byte_q)) begin
                            shift_q <= 1'b1;
                        end else if (lut_mapped) begin
                            push_q      <= 1'b1;
                            push_data_q <= lut_ascii;
                        end
                    end
                    BRK: begin
                        if (is_shift_code(byte_q)) begin
                            shift_q <= 1'b0;
                        end
                        dstate_q <= NORMAL;
                    end
                    EXT: begin
                        // Extended keys never yield ASCII
                        dstate_q <= (byte_q == SC_BREAK) ? EXT_BRK : NORMAL;
                    end
                    EXT_BRK: dstate_q <= NORMAL;
                    default: dstate_q <= NORMAL;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // ASCII FIFO (extra pointer MSB distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        overflow_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        do_pop;
    logic        do_push;
    logic        drop;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                        (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // alongside a pop is accepted
    assign do_pop     = rd_en & ~fifo_empty;
    assign do_push    = push_q & (~fifo_full | do_pop);
    assign drop       = push_q & fifo_full & ~do_pop;

    // Pointer advance
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointers and the sticky overflow flag (a drop beats a clear)
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage; contents are don't-care while the pointers say empty
    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data_q;
        end
    end

    assign rd_data   = fifo_empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    assign rd_empty  = fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
